// File: rtl/simon_key_unroll.sv
// simon_key_unroll: Simon 96/96 key schedule (N=48, M=2, T=52) that first
// expands the master key forward to the last round-key pair, then walks the
// schedule backwards, emitting round keys T-1 down to 0 over a valid/ready
// handshake. Only two words of state are kept at any time.
// Optional feature macro: SIMON_KEY_UNROLL_SELFCHECK_EN adds o_key_err, which
// flags a mismatch between the latched master key and the regenerated
// k[1]/k[0] at the end of a run.
module simon_key_unroll #(
  parameter int N = 48,
  parameter int M = 2,
  parameter int T = 52
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N*M-1:0] i_key,
  output logic           o_busy,
  output logic           o_rk_valid,
  input  logic           i_rk_ready,
  output logic [N-1:0]   o_rk,
  output logic [6:0]     o_rk_idx,
  output logic           o_done
`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
  ,
  output logic           o_key_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  // Simon z_2 constant sequence, MSB first so that z(0) is bit 61.
  localparam logic [61:0] Z2 =
    62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11;
  localparam logic [N-1:0] C_CONST = {{(N-2){1'b1}}, 2'b00};
  localparam logic [6:0]   STEPS   = 7'(T - M);
  localparam logic [6:0]   LAST_IDX = 7'(T - 1);

  // Round-function mix: rotate right 3 XOR rotate right 4.
  function automatic logic [N-1:0] f_mix(input logic [N-1:0] x);
    return {x[2:0], x[N-1:3]} ^ {x[3:0], x[N-1:4]};
  endfunction

  // z(j) with j taken modulo the 62-bit sequence period.
  function automatic logic z_bit(input int j);
    int       r;
    logic [5:0] pos;
    r = j % 62;
    if (r < 0) begin
      r = r + 62;
    end
    pos = 6'(61 - r);
    return Z2[pos];
  endfunction

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_lo;
  logic [N-1:0] r_hi;
  logic [6:0]   r_step;
  logic [6:0]   r_idx;
  logic         r_done;
  logic         w_xfer;
  logic [N-1:0] w_fwd;
  logic [N-1:0] w_inv;
`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
  logic [N*M-1:0] r_key;
  logic           r_err_hi;
  logic           r_key_err;
`endif

  assign w_xfer = (r_state == S_EMIT) && i_rk_ready;
  // Forward: k[j+2] from (lo,hi)=(k[j],k[j+1]) with j = step count.
  assign w_fwd  = C_CONST ^ {{(N-1){1'b0}}, z_bit(int'(r_step))} ^ r_lo ^ f_mix(r_hi);
  // Inverse: k[idx-2] from (lo,hi)=(k[idx-1],k[idx]).
  assign w_inv  = r_hi ^ C_CONST ^ {{(N-1){1'b0}}, z_bit(int'(r_idx) - 2)} ^ f_mix(r_lo);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_EXPAND;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXPAND: begin
        if (r_step == STEPS) begin
          w_next_state = S_EMIT;
        end else begin
          w_next_state = S_EXPAND;
        end
      end
      S_EMIT: begin
        if (w_xfer && (r_idx == 7'd0)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_EMIT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Key pair, counters and done pulse: expand forward, then unwind on each transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_step <= 7'd0;
      r_idx  <= 7'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_lo   <= i_key[N-1:0];
            r_hi   <= i_key[2*N-1:N];
            r_step <= 7'd0;
          end
        end
        S_EXPAND: begin
          if (r_step == STEPS) begin
            r_idx <= LAST_IDX;
          end else begin
            r_lo   <= r_hi;
            r_hi   <= w_fwd;
            r_step <= r_step + 7'd1;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (r_idx >= 7'd2) begin
              r_hi  <= r_lo;
              r_lo  <= w_inv;
              r_idx <= r_idx - 7'd1;
            end else if (r_idx == 7'd1) begin
              r_hi  <= r_lo;
              r_idx <= 7'd0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_step <= 7'd0;
        end
      endcase
    end
  end

`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
  // Master-key latch and regenerated-key comparison at the k[1] and k[0] transfers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key     <= '0;
      r_err_hi  <= 1'b0;
      r_key_err <= 1'b0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_key     <= i_key;
      r_err_hi  <= 1'b0;
      r_key_err <= 1'b0;
    end else if (w_xfer && (r_idx == 7'd1)) begin
      r_err_hi  <= (r_hi != r_key[2*N-1:N]);
    end else if (w_xfer && (r_idx == 7'd0)) begin
      r_key_err <= r_err_hi | (r_hi != r_key[N-1:0]);
    end
  end

  assign o_key_err = r_key_err;
`endif

  assign o_busy     = (r_state != S_IDLE);
  assign o_rk_valid = (r_state == S_EMIT);
  assign o_rk       = r_hi;
  assign o_rk_idx   = r_idx;
  assign o_done     = r_done;

endmodule

// File: tb/tb_simon_key_unroll.sv
// Bench for simon_key_unroll: an independent forward model fills a scoreboard
// with the expected round keys (index T-1 down to 0) when a run is started;
// every handshake transfer pops and compares. Also checks latency, stalls,
// ignored start pulses, and asynchronous reset in the middle of emission.
module tb_simon_key_unroll;
  localparam int N = 48;
  localparam int T = 52;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [2*N-1:0] i_key;
  logic          o_busy;
  logic          o_rk_valid;
  logic          i_rk_ready;
  logic [N-1:0]  o_rk;
  logic [6:0]    o_rk_idx;
  logic          o_done;
`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
  logic          o_key_err;
`endif

  simon_key_unroll #(.N(48), .M(2), .T(52)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_key      (i_key),
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .i_rk_ready (i_rk_ready),
    .o_rk       (o_rk),
    .o_rk_idx   (o_rk_idx),
    .o_done     (o_done)
`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
    ,
    .o_key_err  (o_key_err)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] exp_rk_q[$];
  logic [6:0]   exp_idx_q[$];
  logic [61:0]  z2_seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  function automatic logic zb(input int j);
    logic [61:0] t;
    t = z2_seq >> (61 - (j % 62));
    return t[0];
  endfunction

  // Software forward key schedule; pushes expected keys in emission order.
  task automatic load_model(input logic [2*N-1:0] key);
    logic [N-1:0] k[0:T-1];
    logic [N-1:0] c;
    c = {{(N-2){1'b1}}, 2'b00};
    k[0] = key[N-1:0];
    k[1] = key[2*N-1:N];
    for (int j = 0; j < T - 2; j++) begin
      k[j+2] = c ^ {{(N-1){1'b0}}, zb(j)} ^ k[j] ^ ror(k[j+1], 3) ^ ror(k[j+1], 4);
    end
    for (int i = T - 1; i >= 0; i--) begin
      exp_rk_q.push_back(k[i]);
      exp_idx_q.push_back(7'(i));
    end
  endtask

  // One full run. mode 0: ready always 1; 1: random ready; 2: 20-cycle stall at idx 51.
  task automatic run(input logic [2*N-1:0] key, input int mode, input bit inject, input bit zero_chk);
    int e, done_e, dones, xfers, stall;
    bit first_seen, prev_stall;
    logic [N-1:0] prev_rk, erk, tail;
    logic [6:0]   prev_idx, eidx;
    load_model(key);
    i_key = key;
    i_start = 1'b1;
    i_rk_ready = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_key = ~key;
    e = 0; done_e = -1; dones = 0; xfers = 0; stall = 0;
    first_seen = 1'b0; prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
    while (e < 3000 && (done_e < 0 || e < done_e + 3)) begin
      i_start = inject && (e == 20 || e == 60);
      if (i_start) i_key = {$urandom, $urandom, $urandom};
      case (mode)
        0: i_rk_ready = 1'b1;
        1: i_rk_ready = 1'($urandom_range(0, 1));
        default: begin
          i_rk_ready = !(o_rk_valid && o_rk_idx == 7'd51 && stall < 20);
          if (!i_rk_ready && o_rk_valid) stall++;
        end
      endcase
      @(negedge i_clk);
      if (inject && (e == 20 || e == 60)) chk("busy_on_start_pulse", 64'(o_busy), 64'd1);
      if (prev_stall) begin
        chk("stall_valid_held", 64'(o_rk_valid), 64'd1);
        chk("stall_rk_stable", 64'(o_rk), 64'(prev_rk));
        chk("stall_idx_stable", 64'(o_rk_idx), 64'(prev_idx));
      end
      if (o_rk_valid && !first_seen) begin
        first_seen = 1'b1;
        chk("first_valid_latency", 64'(e), 64'd51);
        chk("first_valid_idx", 64'(o_rk_idx), 64'd51);
      end
      if (o_done) begin
        dones++;
        if (done_e < 0) done_e = e;
      end
      if (o_rk_valid && i_rk_ready) begin
        xfers++;
        if (exp_rk_q.size() == 0) begin
          chk("extra_transfer", 64'(xfers), 64'(T));
        end else begin
          erk = exp_rk_q.pop_front();
          eidx = exp_idx_q.pop_front();
          chk("rk_value", 64'(o_rk), 64'(erk));
          chk("rk_idx", 64'(o_rk_idx), 64'(eidx));
          if (zero_chk && o_rk_idx <= 7'd2) begin
            tail = (o_rk_idx == 7'd2) ? 48'hFFFF_FFFF_FFFD : 48'h0;
            chk("zero_key_tail", 64'(o_rk), 64'(tail));
          end
        end
      end
      prev_stall = o_rk_valid && !i_rk_ready;
      prev_rk = o_rk;
      prev_idx = o_rk_idx;
      @(posedge i_clk); #1;
      e++;
    end
    i_start = 1'b0;
    chk("first_valid_seen", 64'(first_seen), 64'd1);
    chk("done_pulses", 64'(dones), 64'd1);
    chk("transfer_count", 64'(xfers), 64'(T));
    chk("scoreboard_drained", 64'(exp_rk_q.size()), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_valid", 64'(o_rk_valid), 64'd0);
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd20);
`ifdef SIMON_KEY_UNROLL_SELFCHECK_EN
    chk("key_err", 64'(o_key_err), 64'd0);
`endif
    exp_rk_q.delete();
    exp_idx_q.delete();
  endtask

  // Asynchronous reset while rk_idx is 30, then confirm silence until next start.
  task automatic reset_mid_emit(input logic [2*N-1:0] key);
    int e, seen;
    bit hit;
    i_key = key;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_rk_ready = 1'b1;
    hit = 1'b0;
    e = 0;
    while (!hit && e < 500) begin
      @(negedge i_clk);
      if (o_rk_valid && o_rk_idx == 7'd30) begin
        hit = 1'b1;
        i_rst = 1'b1;
        #1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_valid", 64'(o_rk_valid), 64'd0);
        chk("rst_rk", 64'(o_rk), 64'd0);
        chk("rst_idx", 64'(o_rk_idx), 64'd0);
      end else begin
        @(posedge i_clk); #1;
        e++;
      end
    end
    chk("rst_idx30_reached", 64'(hit), 64'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_rk_valid || o_done || o_busy) seen++;
      @(posedge i_clk); #1;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);
  endtask

  initial begin
    z2_seq = 62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_rk_ready = 1'b0;
    i_key = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_valid", 64'(o_rk_valid), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_rk", 64'(o_rk), 64'd0);
    chk("reset_idx", 64'(o_rk_idx), 64'd0);
    i_rst = 1'b0;
    i_rk_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("idle_no_activity", 64'({o_busy, o_rk_valid, o_done}), 64'd0);

    run('0, 0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run({$urandom, $urandom, $urandom}, 1, 1'b0, 1'b0);
    end
    run({$urandom, $urandom, $urandom}, 0, 1'b1, 1'b0);
    run({$urandom, $urandom, $urandom}, 1, 1'b1, 1'b0);
    run({$urandom, $urandom, $urandom}, 2, 1'b0, 1'b0);
    reset_mid_emit({$urandom, $urandom, $urandom});
    run({$urandom, $urandom, $urandom}, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
